// File: rtl/spi_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : spi_pkg                                                      |
// | Description : Shared types and constants for the SPI mode-0 responder.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package spi_pkg;

    // Responder FSM states; two bits cover the three states explicitly.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2
    } spi_state_e;

    // SPI mode 0: clock idles low, data sampled on the leading (rising) edge.
    localparam logic SPI_CPOL           = 1'b0;
    localparam logic SPI_CPHA           = 1'b0;

    localparam int   SPI_DEFAULT_DATA_W = 8;

endpackage : spi_pkg
`default_nettype wire

// File: rtl/spi_sync_edge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : spi_sync_edge                                                |
// | Description : Multi-stage synchroniser for one asynchronous SPI pin, plus  |
// |               single-cycle rise/fall pulses from one extra history flop.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module spi_sync_edge
    import spi_pkg::*;
#(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = SPI_CPOL
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   prev_q;
    logic                   prev_d;

    // Next values: shift the pin into the chain, remember the last synced level.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], i_async};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    // Synchroniser and edge-history registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign o_level = sync_q[SYNC_STAGES-1];
    assign o_rise  =  o_level & ~prev_q;
    assign o_fall  = ~o_level &  prev_q;

endmodule : spi_sync_edge
`default_nettype wire

// File: rtl/spi_slave.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : spi_slave                                                    |
// | Description : SPI mode-0 responder, MSB first, oversampled in the sclk     |
// |               domain. Multi-byte frames while SPI_CSN is low; received     |
// |               words on a one-cycle strobe, transmit words pulled through   |
// |               a valid/ready handshake.                                     |
// |               Build option SPI_SLAVE_MISO_HIZ_EN: tri-state MISO when the  |
// |               responder is deselected.                                     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module spi_slave
    import spi_pkg::*;
#(
    parameter int DATA_W      = SPI_DEFAULT_DATA_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic              sclk,
    input  logic              rst_n,
    input  logic              SPI_SCLK,
    input  logic              SPI_CSN,
    input  logic              SPI_MOSI,
    output logic              SPI_MISO,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              tx_underrun,
    output logic              busy
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    // Synchronised pins and edge pulses
    logic sclk_level_unused;
    logic sclk_rise;
    logic sclk_fall;
    logic csn_sync;
    logic csn_rise;
    logic csn_fall;
    logic mosi_sync;
    logic mosi_rise_unused;
    logic mosi_fall_unused;

    // Clock and chip-select chains reset to 0 so that a frame already in
    // progress at reset release produces no CSN fall; a rise must be seen first.
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(SPI_CPOL)) u_sync_sclk (
        .clk     (sclk),
        .rst_n   (rst_n),
        .i_async (SPI_SCLK),
        .o_level (sclk_level_unused),
        .o_rise  (sclk_rise),
        .o_fall  (sclk_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_csn (
        .clk     (sclk),
        .rst_n   (rst_n),
        .i_async (SPI_CSN),
        .o_level (csn_sync),
        .o_rise  (csn_rise),
        .o_fall  (csn_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk     (sclk),
        .rst_n   (rst_n),
        .i_async (SPI_MOSI),
        .o_level (mosi_sync),
        .o_rise  (mosi_rise_unused),
        .o_fall  (mosi_fall_unused)
    );

    // Mode 0 samples on the leading edge and shifts on the trailing edge.
    logic sample_edge;
    logic shift_edge;
    assign sample_edge = (SPI_CPOL ^ SPI_CPHA) ? sclk_fall : sclk_rise;
    assign shift_edge  = (SPI_CPOL ^ SPI_CPHA) ? sclk_rise : sclk_fall;

    // State
    spi_state_e        state_q,          state_d;
    logic [DATA_W-1:0] tx_sh_q,          tx_sh_d;
    logic [DATA_W-1:0] rx_sh_q,          rx_sh_d;
    logic [DATA_W-1:0] rx_data_q,        rx_data_d;
    logic              rx_valid_q,       rx_valid_d;
    logic [CNT_W-1:0]  bit_cnt_q,        bit_cnt_d;
    logic              reload_pending_q, reload_pending_d;
    logic              tx_underrun_q,    tx_underrun_d;
    logic              load_word;
    logic              end_frame;
    logic [DATA_W-1:0] rx_word;

    assign rx_word = {rx_sh_q[DATA_W-2:0], mosi_sync};

    // Next-state, shift/count and handshake logic; CSN rise outranks SCLK edges.
    always_comb begin
        state_d          = state_q;
        tx_sh_d          = tx_sh_q;
        rx_sh_d          = rx_sh_q;
        rx_data_d        = rx_data_q;
        rx_valid_d       = 1'b0;
        bit_cnt_d        = bit_cnt_q;
        reload_pending_d = reload_pending_q;
        tx_underrun_d    = tx_underrun_q;
        tx_ready         = 1'b0;
        load_word        = 1'b0;
        end_frame        = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                bit_cnt_d = '0;
                if (csn_fall) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (csn_rise) begin
                    end_frame = 1'b1;
                end else begin
                    load_word = 1'b1;
                    bit_cnt_d = '0;
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (csn_rise) begin
                    end_frame = 1'b1;
                end else if (sample_edge) begin
                    rx_sh_d = rx_word;
                    if (bit_cnt_q == LAST_BIT) begin
                        rx_data_d        = rx_word;
                        rx_valid_d       = 1'b1;
                        bit_cnt_d        = '0;
                        reload_pending_d = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end else if (shift_edge) begin
                    if (reload_pending_q) begin
                        load_word        = 1'b1;
                        reload_pending_d = 1'b0;
                    end else begin
                        tx_sh_d = tx_sh_q << 1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Leaving the frame discards any partial word and clears sticky flags.
        if (end_frame) begin
            state_d          = ST_IDLE;
            tx_sh_d          = '0;
            bit_cnt_d        = '0;
            reload_pending_d = 1'b0;
            tx_underrun_d    = 1'b0;
        end

        // Word load: take tx_data when offered, otherwise send zeros and flag it.
        if (load_word) begin
            tx_sh_d  = tx_valid ? tx_data : '0;
            tx_ready = tx_valid;
            if (!tx_valid) begin
                tx_underrun_d = 1'b1;
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= ST_IDLE;
            tx_sh_q          <= '0;
            rx_sh_q          <= '0;
            rx_data_q        <= '0;
            rx_valid_q       <= 1'b0;
            bit_cnt_q        <= '0;
            reload_pending_q <= 1'b0;
            tx_underrun_q    <= 1'b0;
        end else begin
            state_q          <= state_d;
            tx_sh_q          <= tx_sh_d;
            rx_sh_q          <= rx_sh_d;
            rx_data_q        <= rx_data_d;
            rx_valid_q       <= rx_valid_d;
            bit_cnt_q        <= bit_cnt_d;
            reload_pending_q <= reload_pending_d;
            tx_underrun_q    <= tx_underrun_d;
        end
    end

    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign tx_underrun = tx_underrun_q;
    assign busy        = (state_q != ST_IDLE);

`ifdef SPI_SLAVE_MISO_HIZ_EN
    // Shared MISO bus: release the line while deselected.
    assign SPI_MISO = csn_sync ? 1'bz : tx_sh_q[DATA_W-1];
`else
    // Point-to-point MISO: park low while deselected.
    assign SPI_MISO = csn_sync ? 1'b0 : tx_sh_q[DATA_W-1];
`endif

endmodule : spi_slave
`default_nettype wire

// File: tb/tb_spi_slave.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_spi_slave                                                 |
// | Description : Directed self-checking bench for spi_slave (mode 0, 8 bit).  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_spi_slave;

    localparam int HALF = 8;   // SPI half period in sclk cycles

    logic       sclk;
    logic       rst_n;
    logic       spi_sclk;
    logic       spi_csn;
    logic       spi_mosi;
    wire        spi_miso;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_underrun;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;
    int ready_cnt = 0;
    logic [7:0] tx_q[$];
    logic [7:0] rx_log[$];

    spi_slave #(.DATA_W(8), .SYNC_STAGES(2)) dut (
        .sclk        (sclk),
        .rst_n       (rst_n),
        .SPI_SCLK    (spi_sclk),
        .SPI_CSN     (spi_csn),
        .SPI_MOSI    (spi_mosi),
        .SPI_MISO    (spi_miso),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .tx_underrun (tx_underrun),
        .busy        (busy)
    );

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge sclk);
        #1;
    endtask

    // Master side: drive nbits mode-0 bits from the top of mosi_w, capture MISO.
    task automatic spi_bits(input int nbits, input logic [15:0] mosi_w, output logic [15:0] miso_w);
        logic [15:0] sh;
        sh       = mosi_w;
        miso_w   = '0;
        spi_csn  = 1'b0;
        spi_mosi = sh[15];
        wait_clk(HALF);
        for (int i = 0; i < nbits; i++) begin
            miso_w   = {miso_w[14:0], spi_miso};
            spi_sclk = 1'b1;
            wait_clk(HALF);
            spi_sclk = 1'b0;
            sh       = sh << 1;
            spi_mosi = sh[15];
            wait_clk(HALF);
        end
    endtask

    task automatic spi_end();
        spi_csn  = 1'b1;
        spi_mosi = 1'b0;
        wait_clk(2 * HALF);
    endtask

    // Transmit source and receive monitor: sample mid-cycle, update after the edge.
    initial begin
        logic seen_ready;
        tx_valid = 1'b0;
        tx_data  = '0;
        forever begin
            @(negedge sclk);
            seen_ready = tx_ready;
            if (tx_ready) ready_cnt++;
            if (rx_valid) rx_log.push_back(rx_data);
            @(posedge sclk);
            #1;
            if (seen_ready && tx_q.size() > 0) void'(tx_q.pop_front());
            tx_valid = (tx_q.size() > 0);
            tx_data  = (tx_q.size() > 0) ? tx_q[0] : 8'h00;
        end
    end

    initial begin
        logic [15:0] miso_w;
        int          rx_base;
        int          rdy_base;

        rst_n    = 1'b0;
        spi_sclk = 1'b0;
        spi_csn  = 1'b1;
        spi_mosi = 1'b0;
        wait_clk(4);
        rst_n = 1'b1;
        #1;

        // Reset state
        check_eq("rst_rx_data",  32'(rx_data),     32'h00);
        check_eq("rst_rx_valid", 32'(rx_valid),    32'h0);
        check_eq("rst_tx_ready", 32'(tx_ready),    32'h0);
        check_eq("rst_busy",     32'(busy),        32'h0);
        check_eq("rst_underrun", 32'(tx_underrun), 32'h0);
        check_eq("rst_miso",     32'(spi_miso),    32'h0);
        wait_clk(2 * HALF);

        // Idle MISO level
`ifdef SPI_SLAVE_MISO_HIZ_EN
        check_eq("idle_miso", 32'(spi_miso), 32'(1'bz));
`else
        check_eq("idle_miso", 32'(spi_miso), 32'h0);
`endif

        // Frame 1: no transmit data, MOSI A5
        rx_base  = rx_log.size();
        rdy_base = ready_cnt;
        spi_bits(8, 16'hA500, miso_w);
        wait_clk(HALF);
        check_eq("f1_underrun_low", 32'(tx_underrun), 32'h1);
        check_eq("f1_busy",         32'(busy),        32'h1);
        spi_end();
        check_eq("f1_underrun_clr", 32'(tx_underrun), 32'h0);
        check_eq("f1_rx_count",     rx_log.size() - rx_base, 32'd1);
        check_eq("f1_rx_data",      32'(rx_data),     32'hA5);
        check_eq("f1_miso",         32'(miso_w[7:0]), 32'h00);
        check_eq("f1_ready_count",  ready_cnt - rdy_base, 32'd0);

        // Frame 2: tx 3C, MOSI C3
        tx_q.push_back(8'h3C);
        wait_clk(2);
        rx_base  = rx_log.size();
        rdy_base = ready_cnt;
        spi_bits(8, 16'hC300, miso_w);
        spi_end();
        check_eq("f2_ready_count", ready_cnt - rdy_base, 32'd1);
        check_eq("f2_miso",        32'(miso_w[7:0]), 32'h3C);
        check_eq("f2_rx_count",    rx_log.size() - rx_base, 32'd1);
        check_eq("f2_rx_data",     32'(rx_data),     32'hC3);

        // Frame 3: two words with CSN held low
        tx_q.push_back(8'h12);
        tx_q.push_back(8'h34);
        wait_clk(2);
        rx_base  = rx_log.size();
        rdy_base = ready_cnt;
        spi_bits(16, 16'h5AA5, miso_w);
        spi_end();
        check_eq("f3_ready_count", ready_cnt - rdy_base, 32'd2);
        check_eq("f3_miso",        32'(miso_w),      32'h1234);
        check_eq("f3_rx_count",    rx_log.size() - rx_base, 32'd2);
        if (rx_log.size() - rx_base == 2) begin
            check_eq("f3_rx_word0", 32'(rx_log[rx_base]),     32'h5A);
            check_eq("f3_rx_word1", 32'(rx_log[rx_base + 1]), 32'hA5);
        end

        // Frame 4: abort after 5 bits, then a full FF frame
        rx_base = rx_log.size();
        spi_bits(5, 16'hF800, miso_w);
        spi_end();
        check_eq("f4_abort_rx_count", rx_log.size() - rx_base, 32'd0);
        check_eq("f4_abort_busy",     32'(busy), 32'h0);
        spi_bits(8, 16'hFF00, miso_w);
        spi_end();
        check_eq("f4_rx_count", rx_log.size() - rx_base, 32'd1);
        check_eq("f4_rx_data",  32'(rx_data),   32'hFF);

        // Reset mid-frame at bit 3
        spi_bits(3, 16'hB000, miso_w);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_rx_data",  32'(rx_data),     32'h00);
        check_eq("mid_rst_rx_valid", 32'(rx_valid),    32'h0);
        check_eq("mid_rst_tx_ready", 32'(tx_ready),    32'h0);
        check_eq("mid_rst_busy",     32'(busy),        32'h0);
        check_eq("mid_rst_underrun", 32'(tx_underrun), 32'h0);
        check_eq("mid_rst_miso",     32'(spi_miso),    32'h0);
        wait_clk(3);
        rst_n = 1'b1;
        rx_base = rx_log.size();
        spi_bits(8, 16'h6900, miso_w);
        check_eq("post_rst_busy",     32'(busy), 32'h0);
        spi_end();
        check_eq("post_rst_rx_count", rx_log.size() - rx_base, 32'd0);
        spi_bits(8, 16'h9600, miso_w);
        spi_end();
        check_eq("fresh_rx_count", rx_log.size() - rx_base, 32'd1);
        check_eq("fresh_rx_data",  32'(rx_data), 32'h96);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_spi_slave
`default_nettype wire
